// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dm_arb_pkg;

  localparam int unsigned DM_ARB_WAIT_W = 4;
  localparam int unsigned DM_ARB_ADDR_W = 8;
  localparam int unsigned DM_ARB_DATA_W = 8;

  // Owner of the read whose data returns from memory in the following cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } rd_owner_t;

  // Request presented to the memory macro by whichever requester holds the grant.
  typedef struct packed {
    logic                     we;
    logic [DM_ARB_ADDR_W-1:0] addr;
    logic [DM_ARB_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bundle of CPU, debug and memory-side signals around the data-memory arbiter.
// slave = arbiter view, master = environment (CPU, debug port, memory) view.
interface dm_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_valid;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ready;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_valid, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_stall, cpu_rdata,
    output dbg_ready, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_valid, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_stall, cpu_rdata,
    input  dbg_ready, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_arb_starve_cnt.sv
// Saturating wait counter for the debug requester; raises force_dbg_o once
// a valid debug request has been passed over MAX_WAIT times in a row.
module dm_arb_starve_cnt
  import dm_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic dbg_valid_i,
  input  logic grant_dbg_i,
  output logic force_dbg_o
);

  localparam logic [DM_ARB_WAIT_W-1:0] MaxWait = DM_ARB_WAIT_W'(MAX_WAIT);

  logic [DM_ARB_WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Next count: clear when served or idle, otherwise count up to MaxWait.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (grant_dbg_i || !dbg_valid_i) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MaxWait) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end

  assign force_dbg_o = dbg_valid_i && (wait_cnt_q == MaxWait);

endmodule

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: CPU (priority) vs debug/loader port, one access
// per cycle, read data routed back to its owner via a registered owner tag.
// Optional statistics counters enabled by defining DM_ARB_STATS_EN.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DM_ARB_ADDR_W,
  parameter int unsigned DATA_W   = DM_ARB_DATA_W,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic               sig_clk,
  input  logic               sig_rst,
  dm_port_arbiter_if.slave   bus
`ifdef DM_ARB_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [15:0]        stat_contention,
  output logic [15:0]        stat_forced
`endif
);

  logic      force_dbg;
  logic      grant_dbg;
  logic      grant_cpu;
  mem_req_t  req;
  rd_owner_t rd_owner_q, rd_owner_d;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              dbg_rvalid_q;

  dm_arb_starve_cnt #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve_cnt (
    .clk_i      (sig_clk),
    .rst_i      (sig_rst),
    .dbg_valid_i(bus.dbg_valid),
    .grant_dbg_i(grant_dbg),
    .force_dbg_o(force_dbg)
  );

  // Grant: CPU has priority unless the debug port has waited too long.
  always_comb begin
    grant_dbg = bus.dbg_valid && (!bus.cpu_req || force_dbg);
    grant_cpu = bus.cpu_req && !grant_dbg;
  end

  // Request mux towards memory plus owner tag for a read issued this cycle.
  always_comb begin
    req        = '0;
    rd_owner_d = OWN_NONE;
    if (grant_dbg) begin
      req.we    = bus.dbg_we;
      req.addr  = DM_ARB_ADDR_W'(bus.dbg_addr);
      req.wdata = DM_ARB_DATA_W'(bus.dbg_wdata);
      if (!bus.dbg_we) rd_owner_d = OWN_DBG;
    end else if (grant_cpu) begin
      req.we    = bus.cpu_we;
      req.addr  = DM_ARB_ADDR_W'(bus.cpu_addr);
      req.wdata = DM_ARB_DATA_W'(bus.cpu_wdata);
      if (!bus.cpu_we) rd_owner_d = OWN_CPU;
    end
  end

  assign bus.cpu_stall = bus.cpu_req && !grant_cpu;
  assign bus.dbg_ready = grant_dbg;
  assign bus.mem_en    = grant_cpu || grant_dbg;
  assign bus.mem_we    = req.we;
  assign bus.mem_addr  = ADDR_W'(req.addr);
  assign bus.mem_wdata = DATA_W'(req.wdata);

  // Read-return tracker: memory data arrives the cycle after issue and is
  // captured for whichever requester the tag names; reset drops it.
  always_ff @(posedge sig_clk) begin
    if (sig_rst) begin
      rd_owner_q   <= OWN_NONE;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      rd_owner_q   <= rd_owner_d;
      dbg_rvalid_q <= (rd_owner_q == OWN_DBG);
      if (rd_owner_q == OWN_CPU) cpu_rdata_q <= bus.mem_rdata;
      if (rd_owner_q == OWN_DBG) dbg_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;

`ifdef DM_ARB_STATS_EN
  logic [15:0] stat_cont_q;
  logic [15:0] stat_forced_q;

  // Saturating contention / forced-grant counters, cleared by stat_clr.
  always_ff @(posedge sig_clk) begin
    if (sig_rst || stat_clr) begin
      stat_cont_q   <= '0;
      stat_forced_q <= '0;
    end else begin
      if (bus.cpu_req && bus.dbg_valid && (stat_cont_q != '1))
        stat_cont_q <= stat_cont_q + 1'b1;
      if (force_dbg && (stat_forced_q != '1))
        stat_forced_q <= stat_forced_q + 1'b1;
    end
  end

  assign stat_contention = stat_cont_q;
  assign stat_forced     = stat_forced_q;
`endif

endmodule
